// File: rtl/word2byte_pkg.sv
// -----------------------------------------------------------------------------
// word2byte_pkg
// Shared types and constants for the word-to-byte serializer cell and its
// field placement helper.
//   WORD_W    : width of the Word connection type (16)
//   BYTE_W    : width of the Byte connection type (8)
//   FULL_MASK : all-ones Word, source of the field extraction mask
//   state_e   : serializer FSM states
// -----------------------------------------------------------------------------
package word2byte_pkg;

    localparam int WORD_W = 16;
    localparam int BYTE_W = 8;

    localparam logic [WORD_W-1:0] FULL_MASK = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND_L = 2'd1,
        SEND_H = 2'd2
    } state_e;

endpackage

// File: rtl/word2byte_ser_field_place.sv
// -----------------------------------------------------------------------------
// field_place
// Purely combinational bit-field extract-and-reposition.
//   word_i  : source Word
//   shift_i : left-shift applied to the extracted field (0..15)
//   mask_i  : field width minus one (0..15 -> 1..16 bits, LSB-aligned)
//   held_o  : (word_i & low-(mask_i+1)-bit mask) << shift_i, truncated to 16 bits
// -----------------------------------------------------------------------------
module field_place
    import word2byte_pkg::*;
(
    input  logic [WORD_W-1:0] word_i,
    input  logic [3:0]        shift_i,
    input  logic [3:0]        mask_i,
    output logic [WORD_W-1:0] held_o
);

    logic [WORD_W-1:0] field_mask;
    logic [WORD_W-1:0] field;

    // Shifting the all-ones word right by (15 - width_minus_1) leaves exactly
    // mask_i+1 ones at the bottom; the 4-bit subtraction cannot underflow.
    assign field_mask = FULL_MASK >> (4'd15 - mask_i);
    assign field      = word_i & field_mask;

    // Bits pushed past bit 15 are simply dropped by the fixed result width.
    assign held_o     = field << shift_i;

endmodule

// File: rtl/word2byte_ser.sv
// -----------------------------------------------------------------------------
// word2byte_ser
// Accepts a 16-bit Word, extracts and repositions a bit field, then emits the
// result as a byte stream, low byte first (optionally low byte only).
//   Clk_i, Reset_n_i : clock (rising edge), synchronous active-low reset
//   Word_i, WordValid_i, WordReady_o : word input handshake
//   Shift_i, Mask_i, SingleByte_i    : placement config, sampled at accept
//   Byte_o, ByteValid_o, ByteReady_i, ByteLast_o : byte output handshake
//   Busy_o           : a word is held or being sent
// Every output comes straight from a flop; no input reaches an output
// combinationally.
// -----------------------------------------------------------------------------
module word2byte_ser
    import word2byte_pkg::*;
(
    input  logic              Clk_i,
    input  logic              Reset_n_i,
    input  logic [WORD_W-1:0] Word_i,
    input  logic              WordValid_i,
    output logic              WordReady_o,
    input  logic [3:0]        Shift_i,
    input  logic [3:0]        Mask_i,
    input  logic              SingleByte_i,
    output logic [BYTE_W-1:0] Byte_o,
    output logic              ByteValid_o,
    input  logic              ByteReady_i,
    output logic              ByteLast_o,
    output logic              Busy_o
);

    state_e            state_q, state_d;
    logic [WORD_W-1:0] held_q, held_d;
    logic              single_q, single_d;

    logic [BYTE_W-1:0] byte_q, byte_d;
    logic              byte_valid_q, byte_valid_d;
    logic              byte_last_q, byte_last_d;
    logic              word_ready_q, word_ready_d;
    logic              busy_q, busy_d;

    logic [WORD_W-1:0] placed;

    field_place u_field_place (
        .word_i  (Word_i),
        .shift_i (Shift_i),
        .mask_i  (Mask_i),
        .held_o  (placed)
    );

    // Next-state and held-word logic.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d  = state_q;
        held_d   = held_q;
        single_d = single_q;

        unique case (state_q)
            IDLE: begin
                if (WordValid_i) begin
                    held_d   = placed;
                    single_d = SingleByte_i;
                    state_d  = SEND_L;
                end
            end
            SEND_L: begin
                if (ByteReady_i) begin
                    state_d = single_q ? IDLE : SEND_H;
                end
            end
            SEND_H: begin
                if (ByteReady_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the *next* state so that, once registered,
    // they line up with the state the FSM is entering.
    always_comb begin
        byte_d       = '0;
        byte_valid_d = 1'b0;
        byte_last_d  = 1'b0;
        word_ready_d = (state_d == IDLE);
        busy_d       = (state_d != IDLE);

        unique case (state_d)
            SEND_L: begin
                byte_d       = held_d[BYTE_W-1:0];
                byte_valid_d = 1'b1;
                byte_last_d  = single_d;
            end
            SEND_H: begin
                byte_d       = held_d[WORD_W-1:BYTE_W];
                byte_valid_d = 1'b1;
                byte_last_d  = 1'b1;
            end
            default: ;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples its _d value from before this edge, independent of block order.
    always_ff @(posedge Clk_i) begin
        if (!Reset_n_i) begin
            state_q      <= IDLE;
            // NOTE: the holding register is cleared on reset even though it is
            // only read after a fresh accept; this keeps its value
            // deterministic after an aborted transfer.
            held_q       <= '0;
            single_q     <= 1'b0;
            byte_q       <= '0;
            byte_valid_q <= 1'b0;
            byte_last_q  <= 1'b0;
            word_ready_q <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            held_q       <= held_d;
            single_q     <= single_d;
            byte_q       <= byte_d;
            byte_valid_q <= byte_valid_d;
            byte_last_q  <= byte_last_d;
            word_ready_q <= word_ready_d;
            busy_q       <= busy_d;
        end
    end

    assign Byte_o      = byte_q;
    assign ByteValid_o = byte_valid_q;
    assign ByteLast_o  = byte_last_q;
    assign WordReady_o = word_ready_q;
    assign Busy_o      = busy_q;

endmodule

// File: tb/tb_word2byte_ser.sv
// -----------------------------------------------------------------------------
// tb_word2byte_ser
// Self-checking bench for word2byte_ser: directed cases with literal expected
// bytes, backpressure, reset abort, then randomized words and random consumer
// readiness scored against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_word2byte_ser;

    logic        Clk_i        = 1'b0;
    logic        Reset_n_i    = 1'b0;
    logic [15:0] Word_i       = '0;
    logic        WordValid_i  = 1'b0;
    logic        WordReady_o;
    logic [3:0]  Shift_i      = '0;
    logic [3:0]  Mask_i       = '0;
    logic        SingleByte_i = 1'b0;
    logic [7:0]  Byte_o;
    logic        ByteValid_o;
    logic        ByteReady_i  = 1'b0;
    logic        ByteLast_o;
    logic        Busy_o;

    word2byte_ser dut (
        .Clk_i        (Clk_i),
        .Reset_n_i    (Reset_n_i),
        .Word_i       (Word_i),
        .WordValid_i  (WordValid_i),
        .WordReady_o  (WordReady_o),
        .Shift_i      (Shift_i),
        .Mask_i       (Mask_i),
        .SingleByte_i (SingleByte_i),
        .Byte_o       (Byte_o),
        .ByteValid_o  (ByteValid_o),
        .ByteReady_i  (ByteReady_i),
        .ByteLast_o   (ByteLast_o),
        .Busy_o       (Busy_o)
    );

    always #5 Clk_i = ~Clk_i;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } exp_byte_t;

    exp_byte_t exp_q[$];
    int        tests_run    = 0;
    int        tests_failed = 0;
    bit        rand_ready   = 1'b0;
    bit        ready_fixed  = 1'b1;

    task automatic check(input string tag, input logic [15:0] actual, input logic [15:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    // Reference: keep the low (mask+1) bits, multiply by 2**shift, wrap at 2**16.
    function automatic int unsigned ref_held(input int unsigned w, input int unsigned m,
                                             input int unsigned s);
        int unsigned field;
        field = w % (32'd1 << (m + 1));
        return (field * (32'd1 << s)) % 32'd65536;
    endfunction

    // Sole writer of ByteReady_i; updates land 2 time units after each edge.
    always @(posedge Clk_i) begin
        #2;
        ByteReady_i = rand_ready ? ($urandom_range(0, 3) != 0) : ready_fixed;
    end

    // Monitor/scoreboard: sampled on the falling edge, away from the active edge.
    always @(negedge Clk_i) begin
        if (!Reset_n_i) begin
            exp_q.delete();
        end else begin
            check("busy_matches_model",  16'(Busy_o),      16'(exp_q.size() != 0));
            check("wready_matches_model", 16'(WordReady_o), 16'(exp_q.size() == 0));
            check("bvalid_matches_model", 16'(ByteValid_o), 16'(exp_q.size() != 0));
            if (ByteValid_o && exp_q.size() != 0) begin
                check("stream_byte", 16'(Byte_o),     16'(exp_q[0].data));
                check("stream_last", 16'(ByteLast_o), 16'(exp_q[0].last));
                if (ByteReady_i) void'(exp_q.pop_front());
            end
            if (WordValid_i && WordReady_o) begin
                int unsigned h;
                exp_byte_t   e;
                h = ref_held(Word_i, Mask_i, Shift_i);
                e.data = 8'(h % 256);
                e.last = SingleByte_i;
                exp_q.push_back(e);
                if (!SingleByte_i) begin
                    e.data = 8'(h / 256);
                    e.last = 1'b1;
                    exp_q.push_back(e);
                end
            end
        end
    end

    task automatic send_word(input logic [15:0] w, input logic [3:0] m, input logic [3:0] s,
                             input logic single);
        bit accepted;
        accepted     = 1'b0;
        Word_i       = w;
        Mask_i       = m;
        Shift_i      = s;
        SingleByte_i = single;
        WordValid_i  = 1'b1;
        for (int i = 0; i < 200 && !accepted; i++) begin
            @(negedge Clk_i);
            if (WordReady_o) accepted = 1'b1;
            @(posedge Clk_i);
            #1;
        end
        if (!accepted) check("accept_timeout", 16'd0, 16'd1);
        // Scramble inputs after accept: the held word must not follow them.
        WordValid_i  = 1'b0;
        Word_i       = 16'($urandom);
        Mask_i       = 4'($urandom);
        Shift_i      = 4'($urandom);
        SingleByte_i = 1'($urandom);
    endtask

    // Directed case with ByteReady_i held high; expected Held is a literal.
    task automatic directed(input logic [15:0] w, input logic [3:0] m, input logic [3:0] s,
                            input logic single, input logic [15:0] exp_held);
        logic [7:0] lo;
        logic [7:0] hi;
        lo = exp_held[7:0];
        hi = exp_held[15:8];
        send_word(w, m, s, single);
        @(negedge Clk_i);
        check("dir_lo_byte",  16'(Byte_o),      16'(lo));
        check("dir_lo_valid", 16'(ByteValid_o), 16'd1);
        check("dir_lo_last",  16'(ByteLast_o),  16'(single));
        if (!single) begin
            @(negedge Clk_i);
            check("dir_hi_byte", 16'(Byte_o),     16'(hi));
            check("dir_hi_last", 16'(ByteLast_o), 16'd1);
        end
        @(negedge Clk_i);
        check("dir_ready_again", 16'(WordReady_o), 16'd1);
        @(posedge Clk_i);
        #1;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(posedge Clk_i);
            #1;
            if (exp_q.size() == 0 && !Busy_o) done = 1'b1;
        end
        check("drain_timeout", 16'(done), 16'd1);
    endtask

    initial begin
        // Reset state.
        Reset_n_i = 1'b0;
        repeat (2) @(posedge Clk_i);
        @(negedge Clk_i);
        check("rst_byte",   16'(Byte_o),      16'd0);
        check("rst_bvalid", 16'(ByteValid_o), 16'd0);
        check("rst_blast",  16'(ByteLast_o),  16'd0);
        check("rst_busy",   16'(Busy_o),      16'd0);
        check("rst_wready", 16'(WordReady_o), 16'd1);
        @(posedge Clk_i);
        #1;
        Reset_n_i   = 1'b1;
        ready_fixed = 1'b1;
        @(posedge Clk_i);
        #1;

        // Directed placement cases.
        directed(16'hABCD, 4'd15, 4'd0,  1'b0, 16'hABCD);
        directed(16'h12F3, 4'd7,  4'd4,  1'b0, 16'h0F30);
        directed(16'hABCD, 4'd15, 4'd12, 1'b0, 16'hD000);
        directed(16'h5A3C, 4'd15, 4'd0,  1'b1, 16'h003C);
        directed(16'hFFFF, 4'd0,  4'd15, 1'b0, 16'h8000);
        directed(16'h00F0, 4'd3,  4'd0,  1'b0, 16'h0000);

        // Backpressure with config toggling and a pending new word.
        ready_fixed = 1'b0;
        @(posedge Clk_i);
        #1;
        send_word(16'h1234, 4'd15, 4'd0, 1'b0);
        Word_i       = 16'hCAFE;
        Mask_i       = 4'd15;
        Shift_i      = 4'd0;
        SingleByte_i = 1'b0;
        WordValid_i  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk_i);
            check("stall_byte",   16'(Byte_o),      16'h0034);
            check("stall_valid",  16'(ByteValid_o), 16'd1);
            check("stall_last",   16'(ByteLast_o),  16'd0);
            check("stall_wready", 16'(WordReady_o), 16'd0);
            @(posedge Clk_i);
            #1;
            Shift_i = 4'($urandom);
            Mask_i  = 4'($urandom);
        end
        ready_fixed = 1'b1;
        send_word(16'hCAFE, 4'd15, 4'd0, 1'b0);
        drain();

        // Reset while the high byte is on offer.
        send_word(16'hBEEF, 4'd15, 4'd0, 1'b0);
        @(negedge Clk_i);
        check("abort_lo_byte", 16'(Byte_o), 16'h00EF);
        @(posedge Clk_i);
        #1;
        Reset_n_i = 1'b0;
        @(negedge Clk_i);
        check("abort_in_send_h", 16'(ByteLast_o), 16'd1);
        @(posedge Clk_i);
        #1;
        Reset_n_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk_i);
            check("abort_bvalid", 16'(ByteValid_o), 16'd0);
            check("abort_wready", 16'(WordReady_o), 16'd1);
            check("abort_byte",   16'(Byte_o),      16'd0);
        end
        @(posedge Clk_i);
        #1;

        // Randomized words with random consumer readiness.
        rand_ready = 1'b1;
        for (int n = 0; n < 300; n++) begin
            int gap;
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                @(posedge Clk_i);
                #1;
            end
            send_word(16'($urandom), 4'($urandom), 4'($urandom), ($urandom_range(0, 3) == 0));
        end
        rand_ready  = 1'b0;
        ready_fixed = 1'b1;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/word2byte_ser.md
Name: word2byte_ser

Overview:
- Inverse of the byte-pair-to-word selector cell: takes a 16-bit Word, extracts a bit field and repositions it, then emits the result as a byte stream.
- Order is low byte first, then high byte.
- Sits between Word-typed producers (timers, ADC result logic) and Byte-typed consumers (SPI/I2C/UART transmit paths) in the wsn-soc reconfigurable fabric.
- Valid/ready handshake on both sides.

Parameters:
- none. Widths are fixed at 16 (Word) and 8 (Byte) by the cell-library connection types.

Ports:
- Clk_i  in  1  clock, rising edge
- Reset_n_i  in  1  synchronous, active-low reset
- Word_i  in  16  input word (Word conntype)
- WordValid_i  in  1  Word_i valid
- WordReady_o  out  1  block can accept a word this cycle
- Shift_i  in  4  config: left-shift amount applied to the extracted field (0..15)
- Mask_i  in  4  config: field width minus 1 (0..15 → 1..16 bits)
- SingleByte_i  in  1  config: 1 = send low byte only
- Byte_o  out  8  output byte (Byte conntype)
- ByteValid_o  out  1  Byte_o valid
- ByteReady_i  in  1  consumer accepts byte
- ByteLast_o  out  1  current byte is last of its word
- Busy_o  out  1  word held or being sent

Behaviour:
- Reset values (Reset_n_i=0 at a rising edge): State=IDLE, Byte_o=0, ByteValid_o=0, ByteLast_o=0, Busy_o=0, WordReady_o=1, holding register=0.
- Reset mid-transfer aborts; the held word is discarded and no further bytes are emitted.
- Datapath at word accept:
  - Field = Word_i & (16'hFFFF >> (15 - Mask_i))
  - Held = (Field << Shift_i), truncated to 16 bits; bits shifted past bit 15 are lost.
  - Shift_i, Mask_i and SingleByte_i are sampled only at accept, then held for the whole word. Config changes mid-word have no effect.
- FSM states: IDLE, SEND_L, SEND_H.
  - IDLE:
    - WordReady_o=1.
    - On WordValid_i=1: latch Held and SingleByte, go to SEND_L.
  - SEND_L:
    - ByteValid_o=1, Byte_o=Held[7:0], ByteLast_o=SingleByte.
    - On ByteReady_i=1: go to IDLE if SingleByte, else SEND_H.
  - SEND_H:
    - ByteValid_o=1, Byte_o=Held[15:8], ByteLast_o=1.
    - On ByteReady_i=1: go to IDLE.
- All outputs are registered.
  - WordReady_o = (State==IDLE).
  - Busy_o = (State!=IDLE).
  - ByteValid_o=1 exactly in SEND_L and SEND_H.
- Latency: word accepted at edge N → first byte valid in cycle N+1.
- Throughput with ByteReady_i held high: 2-byte word every 3 cycles; single-byte word every 2 cycles.
- Handshake rules:
  - Byte_o and ByteLast_o stay stable while ByteValid_o=1 and ByteReady_i=0. Backpressure is unbounded.
  - ByteReady_i is ignored when ByteValid_o=0.
  - WordValid_i is ignored when WordReady_o=0. The producer must hold the word until accepted.
- No combinational path from any input to any output.
- Mask_i=15, Shift_i=0 is a pass-through: Held = Word_i.

Decomposition:
- Shared package word2byte_pkg:
  - state enum (IDLE/SEND_L/SEND_H, 2-bit encoding)
  - constant WORD_W=16, BYTE_W=8
  - constant FULL_MASK=16'hFFFF
- Sub-module field_place: purely combinational (Word, Shift, Mask) → Held.
  - Reusable by the companion selector cell's test model.
  - Everything else stays in the top FSM.

Test Plan:
- Word_i=0xABCD, Mask=15, Shift=0, SingleByte=0, ByteReady_i=1 → bytes 0xCD (Last=0), then 0xAB (Last=1) in cycles N+1, N+2; WordReady_o=1 again at N+3.
- Word_i=0x12F3, Mask=7, Shift=4 → Held=0x0F30 → bytes 0x30, then 0x0F.
- Word_i=0xABCD, Mask=15, Shift=12 → Held=0xD000 → bytes 0x00, then 0xD0 (overflow bits dropped).
- SingleByte=1, Word_i=0x5A3C, Mask=15, Shift=0 → single byte 0x3C with Last=1; back to IDLE next cycle.
- Backpressure: ByteReady_i=0 for 5 cycles in SEND_L while Shift_i/Mask_i toggle → Byte_o held at the low byte, unchanged; WordValid_i with a new word is not accepted until IDLE.
- Reset_n_i=0 for one cycle during SEND_H → next cycle IDLE, ByteValid_o=0, WordReady_o=1, and the old high byte is never emitted.
